// File: rtl/frogger_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : frogger_pkg                                                |
// | Description : Shared tile codes, map geometry and writer FSM encodings   |
// |               for the Frogger tilemap path.                              |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package frogger_pkg;

    // Tile codes as stored in each 4-bit nibble of a map word
    localparam logic [3:0] c_TILE_GRASS = 4'h1;
    localparam logic [3:0] c_TILE_ROAD  = 4'h2;

    // Map geometry
    localparam int c_MAP_ROWS   = 15;
    localparam int c_MAP_COLS   = 20;
    localparam int c_ROW_STRIDE = 16;

    // Writer FSM encodings
    localparam int         c_STATE_W       = 3;
    localparam logic [2:0] c_ST_IDLE       = 3'd0;
    localparam logic [2:0] c_ST_WAIT_BLANK = 3'd1;
    localparam logic [2:0] c_ST_GEN        = 3'd2;
    localparam logic [2:0] c_ST_WRITE      = 3'd3;
    localparam logic [2:0] c_ST_DONE       = 3'd4;

endpackage
`default_nettype wire

// File: rtl/map_lfsr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : map_lfsr                                                   |
// | Description : 8-bit Fibonacci LFSR (taps 8,6,5,4) with load and step.   |
// |   i_Clk   clock              i_Rst_L  sync active-low reset (value 0)   |
// |   i_Load  load i_Seed        i_Step   advance one position              |
// |   o_Value current register value                                         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module map_lfsr (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Load,
    input  logic [7:0] i_Seed,
    input  logic       i_Step,
    output logic [7:0] o_Value
);

    logic [7:0] r_lfsr;
    logic       w_fb;
    logic [7:0] w_seed;

    assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // All-zero is the lock-up state of an XOR LFSR; a zero seed is replaced
    // by 8'h01 so a loaded register can always advance.
    assign w_seed = (i_Seed == 8'h00) ? 8'h01 : i_Seed;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_lfsr <= 8'h00;
        end else if (i_Load) begin
            r_lfsr <= w_seed;
        end else if (i_Step) begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
        end
    end

    assign o_Value = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/tilemap_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tilemap_writer                                             |
// | Description : Rebuilds the grass/road tilemap for a level and writes it  |
// |               into the map RAM W port only while i_VBlank is high.       |
// |   i_Clk, i_Rst_L   clock, synchronous active-low reset                   |
// |   i_Start, i_Level rebuild request (IDLE only) and level 0..99           |
// |   i_VBlank         RAM writes permitted                                  |
// |   o_Busy, o_Done   build in progress / one-cycle completion pulse        |
// |   o_Bram_*         registered W-port address, data, write enable         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tilemap_writer
    import frogger_pkg::*;
#(
    parameter int         MAP_ROWS      = c_MAP_ROWS,
    parameter int         WORDS_PER_ROW = 5,
    parameter int         ROW_STRIDE    = c_ROW_STRIDE,
    parameter int         GOAL_ROWS     = 1,
    parameter int         START_ROWS    = 2,
    parameter int         MAX_ROAD_RUN  = 5,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    input  logic        i_Start,
    input  logic [6:0]  i_Level,
    input  logic        i_VBlank,
    output logic        o_Busy,
    output logic        o_Done,
    output logic [10:0] o_Bram_Addr,
    output logic [15:0] o_Bram_Wdata,
    output logic        o_Bram_We
);

    localparam logic [3:0] c_LAST_ROW    = 4'(MAP_ROWS - 1);
    localparam logic [3:0] c_GOAL_END    = 4'(GOAL_ROWS);
    localparam logic [3:0] c_START_BEGIN = 4'(MAP_ROWS - START_ROWS);
    localparam logic [2:0] c_WORDS       = 3'(WORDS_PER_ROW);
    localparam logic [2:0] c_MAX_RUN     = 3'(MAX_ROAD_RUN);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_next;

    logic [3:0]  r_row;
    logic [2:0]  r_word;     // next word of the row to present; c_WORDS = row finished
    logic [2:0]  r_run;      // consecutive road rows so far
    logic [3:0]  r_tile;
    logic [10:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_we;
    logic        r_busy;
    logic        r_done;

    logic        w_accept;
    logic        w_row_end;
    logic        w_last_row;
    logic        w_enter_gen;
    logic        w_grass_zone;
    logic        w_road;
    logic [3:0]  w_tile;
    logic [10:0] w_row_base;
    logic [7:0]  w_seed;
    logic [7:0]  w_lfsr;

    assign w_accept   = (r_state == c_ST_IDLE) && i_Start;
    assign w_row_end  = (r_word == c_WORDS);
    assign w_last_row = (r_row == c_LAST_ROW);
    assign w_seed     = {1'b1, i_Level} ^ LFSR_SEED;

    // The LFSR takes its once-per-row step on the edge that enters GEN, so
    // the value seen in GEN is already the advanced one and the first word
    // can be registered in the same cycle the tile is decided.
    assign w_enter_gen = ((r_state == c_ST_WAIT_BLANK) && i_VBlank) ||
                         ((r_state == c_ST_WRITE) && w_row_end && !w_last_row);

    map_lfsr u_lfsr (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Load  (w_accept),
        .i_Seed  (w_seed),
        .i_Step  (w_enter_gen),
        .o_Value (w_lfsr)
    );

    assign w_grass_zone = (r_row < c_GOAL_END) || (r_row >= c_START_BEGIN);
    assign w_road       = !w_grass_zone && w_lfsr[0] && (r_run < c_MAX_RUN);
    assign w_tile       = w_road ? c_TILE_ROAD : c_TILE_GRASS;
    assign w_row_base   = 11'(r_row) * 11'(ROW_STRIDE);

    // State register
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:       if (i_Start)  w_state_next = c_ST_WAIT_BLANK;
            c_ST_WAIT_BLANK: if (i_VBlank) w_state_next = c_ST_GEN;
            c_ST_GEN:                      w_state_next = c_ST_WRITE;
            c_ST_WRITE: begin
                if (w_row_end) begin
                    w_state_next = w_last_row ? c_ST_DONE : c_ST_GEN;
                end
            end
            c_ST_DONE:                     w_state_next = c_ST_IDLE;
            default:                       w_state_next = c_ST_IDLE;
        endcase
    end

    // Counters and registered W-port outputs. A word is presented with
    // We = i_VBlank; while blanking is off the word index does not advance,
    // so the same address is shown with We=0 until it can be written.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_row   <= 4'd0;
            r_word  <= 3'd0;
            r_run   <= 3'd0;
            r_tile  <= 4'd0;
            r_addr  <= 11'd0;
            r_wdata <= 16'd0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (i_Start) begin
                        r_busy <= 1'b1;
                        r_row  <= 4'd0;
                        r_word <= 3'd0;
                        r_run  <= 3'd0;
                    end
                end
                c_ST_GEN: begin
                    r_tile  <= w_tile;
                    r_run   <= w_road ? (r_run + 3'd1) : 3'd0;
                    r_addr  <= w_row_base;
                    r_wdata <= {4{w_tile}};
                    r_we    <= i_VBlank;
                    r_word  <= i_VBlank ? 3'd1 : 3'd0;
                end
                c_ST_WRITE: begin
                    if (w_row_end) begin
                        if (w_last_row) begin
                            r_done <= 1'b1;
                        end else begin
                            r_row <= r_row + 4'd1;
                        end
                    end else begin
                        r_addr  <= w_row_base + 11'(r_word);
                        r_wdata <= {4{r_tile}};
                        r_we    <= i_VBlank;
                        if (i_VBlank) begin
                            r_word <= r_word + 3'd1;
                        end
                    end
                end
                c_ST_DONE: begin
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_Busy       = r_busy;
    assign o_Done       = r_done;
    assign o_Bram_Addr  = r_addr;
    assign o_Bram_Wdata = r_wdata;
    assign o_Bram_We    = r_we;

endmodule
`default_nettype wire
